// File: rtl/tb_mem_arbiter.sv
// Memory-port arbiter for the test-bench memory model.
// Merges the CPU instruction-fetch port and the data (load/store) port onto
// one memory port with asynchronous read and synchronous write on clk.
// A 32-bit fetch is split into two 16-bit reads (addr, then addr+2).
// All memory drive and returned read data are registered.
// The memory's write clock is tied externally to clk.

package tb_mem_pkg;
   localparam logic cpu_data_acc_sz_8  = 1'b0;
   localparam logic cpu_data_acc_sz_16 = 1'b1;

   typedef struct packed {
      logic [15:0] read_addr_in;
      logic        read_data_acc_sz;
      logic [15:0] write_addr_in;
      logic [15:0] write_data_in;
      logic        write_data_acc_sz;
      logic        write_data_we;
   } tb_mem_inputs;
endpackage

module tb_mem_arbiter
   import tb_mem_pkg::*;
#(
   parameter int unsigned fetch_starve_max = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ifetch_req,
   input  logic [15:0]  ifetch_addr,
   input  logic         ifetch_is_32,
   output logic         ifetch_ack,
   output logic         ifetch_valid,
   output logic [31:0]  ifetch_data,
   input  logic         data_rd_req,
   input  logic         data_wr_req,
   input  logic [15:0]  data_addr,
   input  logic [15:0]  data_wdata,
   input  logic         data_sz,
   output logic         data_ack,
   output logic         data_rvalid,
   output logic [15:0]  data_rdata,
   output tb_mem_inputs mem_inputs,
   input  logic [15:0]  read_data_out,
   output logic         busy
);

   localparam int CNT_W = (fetch_starve_max < 1) ? 1 : $clog2(fetch_starve_max + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(fetch_starve_max);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ACC      = 2'd1;
   localparam logic [1:0] S_FETCH_LO = 2'd2;
   localparam logic [1:0] S_FETCH_HI = 2'd3;

   // Kind of single access in flight, so ACC knows where read data goes.
   localparam logic [1:0] K_LOAD  = 2'd0;
   localparam logic [1:0] K_STORE = 2'd1;
   localparam logic [1:0] K_FETCH = 2'd2;

   logic [1:0]       state;
   logic [1:0]       kind;
   logic [CNT_W-1:0] starve_cnt;
   logic             data_req;
   logic             force_fetch;
   logic             grant_fetch;
   logic             grant_data;

   // Grant decision, only meaningful in IDLE; data wins unless fetch has starved.
   always_comb begin
      data_req    = data_rd_req | data_wr_req;
      force_fetch = ifetch_req && (starve_cnt == STARVE_MAX);
      grant_fetch = (state == S_IDLE) && ifetch_req && (force_fetch || !data_req);
      grant_data  = (state == S_IDLE) && data_req && !grant_fetch;
   end

   // Starvation counter: counts data grants that bypassed a pending fetch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (grant_fetch) begin
         starve_cnt <= '0;
      end else if (grant_data) begin
         if (!ifetch_req)
            starve_cnt <= '0;
         else if (starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Main sequencer: grants, memory drive, read-data capture and pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         kind         <= K_LOAD;
         ifetch_ack   <= 1'b0;
         ifetch_valid <= 1'b0;
         ifetch_data  <= '0;
         data_ack     <= 1'b0;
         data_rvalid  <= 1'b0;
         data_rdata   <= '0;
         mem_inputs   <= '0;
      end else begin
         // Acks and valids are single-cycle pulses unless re-asserted below.
         ifetch_ack   <= 1'b0;
         data_ack     <= 1'b0;
         ifetch_valid <= 1'b0;
         data_rvalid  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (grant_fetch) begin
                  state                        <= ifetch_is_32 ? S_FETCH_LO : S_ACC;
                  kind                         <= K_FETCH;
                  ifetch_ack                   <= 1'b1;
                  mem_inputs.read_addr_in      <= ifetch_addr;
                  mem_inputs.write_addr_in     <= ifetch_addr;
                  mem_inputs.read_data_acc_sz  <= cpu_data_acc_sz_16;
                  mem_inputs.write_data_acc_sz <= data_sz;
                  mem_inputs.write_data_in     <= data_wdata;
                  mem_inputs.write_data_we     <= 1'b0;
               end else if (grant_data) begin
                  // A simultaneous read+write is served as the write; the
                  // read is picked up on a later IDLE cycle if still held.
                  state                        <= S_ACC;
                  kind                         <= data_wr_req ? K_STORE : K_LOAD;
                  data_ack                     <= 1'b1;
                  mem_inputs.read_addr_in      <= data_addr;
                  mem_inputs.write_addr_in     <= data_addr;
                  mem_inputs.read_data_acc_sz  <= data_sz;
                  mem_inputs.write_data_acc_sz <= data_sz;
                  mem_inputs.write_data_in     <= data_wdata;
                  mem_inputs.write_data_we     <= data_wr_req;
               end
            end

            S_ACC: begin
               // The memory commits a store on this same edge.
               state                    <= S_IDLE;
               mem_inputs.write_data_we <= 1'b0;
               case (kind)
                  K_LOAD: begin
                     data_rvalid <= 1'b1;
                     if (mem_inputs.read_data_acc_sz == cpu_data_acc_sz_8)
                        data_rdata <= {8'h00, read_data_out[7:0]};
                     else
                        data_rdata <= read_data_out;
                  end
                  K_FETCH: begin
                     ifetch_valid <= 1'b1;
                     ifetch_data  <= {16'h0000, read_data_out};
                  end
                  default: ;
               endcase
            end

            S_FETCH_LO: begin
               // First word is the upper half; address wraps at 64 KiB.
               state                    <= S_FETCH_HI;
               ifetch_data[31:16]       <= read_data_out;
               mem_inputs.read_addr_in  <= mem_inputs.read_addr_in + 16'd2;
               mem_inputs.write_addr_in <= mem_inputs.read_addr_in + 16'd2;
            end

            S_FETCH_HI: begin
               state             <= S_IDLE;
               ifetch_data[15:0] <= read_data_out;
               ifetch_valid      <= 1'b1;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Directed bench for tb_mem_arbiter with a small byte-addressed memory model.
module tb_tb_mem_arbiter;
   import tb_mem_pkg::*;

   localparam int OP_F16 = 0;
   localparam int OP_F32 = 1;
   localparam int OP_LD  = 2;
   localparam int OP_ST  = 3;
   localparam int NVEC   = 15;

   typedef struct {
      int          op;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        sz;
      logic [31:0] exp_data;
   } vec_t;

   logic         clk;
   logic         reset;
   logic         ifetch_req;
   logic [15:0]  ifetch_addr;
   logic         ifetch_is_32;
   logic         ifetch_ack;
   logic         ifetch_valid;
   logic [31:0]  ifetch_data;
   logic         data_rd_req;
   logic         data_wr_req;
   logic [15:0]  data_addr;
   logic [15:0]  data_wdata;
   logic         data_sz;
   logic         data_ack;
   logic         data_rvalid;
   logic [15:0]  data_rdata;
   tb_mem_inputs mem_inputs;
   logic [15:0]  read_data_out;
   logic         busy;

   int errors = 0;
   int checks = 0;

   tb_mem_arbiter #(.fetch_starve_max(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .ifetch_req   (ifetch_req),
      .ifetch_addr  (ifetch_addr),
      .ifetch_is_32 (ifetch_is_32),
      .ifetch_ack   (ifetch_ack),
      .ifetch_valid (ifetch_valid),
      .ifetch_data  (ifetch_data),
      .data_rd_req  (data_rd_req),
      .data_wr_req  (data_wr_req),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_sz      (data_sz),
      .data_ack     (data_ack),
      .data_rvalid  (data_rvalid),
      .data_rdata   (data_rdata),
      .mem_inputs   (mem_inputs),
      .read_data_out(read_data_out),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory, little-endian words; async read, write on clk.
   logic [7:0]  mem [0:65535];
   logic        bd_we;
   logic [15:0] bd_addr;
   logic [15:0] bd_word;
   logic [15:0] bd_p1;
   logic [15:0] ra_p1;
   logic [15:0] wa_p1;
   assign bd_p1 = bd_addr + 16'd1;
   assign ra_p1 = mem_inputs.read_addr_in + 16'd1;
   assign wa_p1 = mem_inputs.write_addr_in + 16'd1;
   assign read_data_out = {mem[ra_p1], mem[mem_inputs.read_addr_in]};

   // Memory write port, with a backdoor for preloading.
   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_word[7:0];
         mem[bd_p1]   <= bd_word[15:8];
      end else if (mem_inputs.write_data_we) begin
         mem[mem_inputs.write_addr_in] <= mem_inputs.write_data_in[7:0];
         if (mem_inputs.write_data_acc_sz == cpu_data_acc_sz_16)
            mem[wa_p1] <= mem_inputs.write_data_in[15:8];
      end
   end

   // Event counters and longest valid run, sampled mid-cycle.
   int n_we = 0;
   int n_ivalid = 0;
   int n_rvalid = 0;
   int run_v = 0;
   int max_run = 0;
   always @(negedge clk) begin
      if (mem_inputs.write_data_we) n_we = n_we + 1;
      if (ifetch_valid) n_ivalid = n_ivalid + 1;
      if (data_rvalid) n_rvalid = n_rvalid + 1;
      if (ifetch_valid || data_rvalid) run_v = run_v + 1;
      else run_v = 0;
      if (run_v > max_run) max_run = run_v;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " ifetch_ack"},   64'(ifetch_ack),   64'd0);
      check({tag, " ifetch_valid"}, 64'(ifetch_valid), 64'd0);
      check({tag, " ifetch_data"},  64'(ifetch_data),  64'd0);
      check({tag, " data_ack"},     64'(data_ack),     64'd0);
      check({tag, " data_rvalid"},  64'(data_rvalid),  64'd0);
      check({tag, " data_rdata"},   64'(data_rdata),   64'd0);
      check({tag, " mem_inputs"},   64'(mem_inputs),   64'd0);
      check({tag, " busy"},         64'(busy),         64'd0);
   endtask

   task automatic poke(input logic [15:0] a, input logic [15:0] w);
      @(negedge clk);
      bd_addr = a;
      bd_word = w;
      bd_we   = 1'b1;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   // Applies one transaction starting just after a rising edge.
   task automatic run_vec(input int idx, input vec_t v);
      int          ack_at, val_at, nval, we0, exp_val_at, exp_nval;
      logic        is_f, ack_now, val_now;
      logic [31:0] got, cur;
      logic [15:0] hi_addr;
      we0 = n_we; ack_at = -1; val_at = -1; nval = 0; got = '0;
      is_f = (v.op == OP_F16) || (v.op == OP_F32);
      hi_addr = v.addr + 16'd2;
      data_addr = v.addr; data_wdata = v.wdata; data_sz = v.sz;
      ifetch_addr = v.addr; ifetch_is_32 = (v.op == OP_F32);
      if (is_f) ifetch_req = 1'b1;
      else if (v.op == OP_LD) data_rd_req = 1'b1;
      else data_wr_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         ack_now = is_f ? ifetch_ack : data_ack;
         val_now = is_f ? ifetch_valid : data_rvalid;
         if (ack_now && ack_at < 0) begin
            ack_at = c;
            ifetch_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0;
         end
         if (v.op == OP_F32 && ack_at > 0 && c == ack_at + 1)
            check($sformatf("v%0d fetch_hi_addr", idx), 64'(mem_inputs.read_addr_in), 64'(hi_addr));
         if (val_now) begin
            nval++;
            if (val_at < 0) begin
               val_at = c;
               got = is_f ? ifetch_data : {16'h0000, data_rdata};
            end
         end
      end
      ifetch_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0;
      exp_val_at = (v.op == OP_F32) ? 3 : (v.op == OP_ST) ? -1 : 2;
      exp_nval   = (v.op == OP_ST) ? 0 : 1;
      check($sformatf("v%0d ack_cycle", idx),   64'(ack_at), 64'(1));
      check($sformatf("v%0d valid_cycle", idx), 64'(val_at), 64'(exp_val_at));
      check($sformatf("v%0d valid_count", idx), 64'(nval),   64'(exp_nval));
      check($sformatf("v%0d we_cycles", idx),   64'(n_we - we0), 64'((v.op == OP_ST) ? 1 : 0));
      if (v.op != OP_ST) begin
         cur = is_f ? ifetch_data : {16'h0000, data_rdata};
         check($sformatf("v%0d data", idx), 64'(got), 64'(v.exp_data));
         check($sformatf("v%0d data_hold", idx), 64'(cur), 64'(v.exp_data));
      end
   endtask

   vec_t vecs [NVEC];
   int   gkind [32];
   int   gcyc  [32];
   int   ng, we0, rv0, iv0, ack1, ack2, rv_at, wr_at1, wr_at2;
   logic [15:0] rd_got;

   initial begin
      vecs[0]  = '{OP_F16, 16'h0000, 16'h0000, cpu_data_acc_sz_16, 32'h0000_1234};
      vecs[1]  = '{OP_ST,  16'h0000, 16'h5555, cpu_data_acc_sz_16, 32'h0};
      vecs[2]  = '{OP_F32, 16'hFFFE, 16'h0000, cpu_data_acc_sz_16, 32'hAAAA_5555};
      vecs[3]  = '{OP_ST,  16'h0101, 16'h77AB, cpu_data_acc_sz_8,  32'h0};
      vecs[4]  = '{OP_LD,  16'h0101, 16'h0000, cpu_data_acc_sz_8,  32'h0000_00AB};
      vecs[5]  = '{OP_LD,  16'h0100, 16'h0000, cpu_data_acc_sz_16, 32'h0000_AB5A};
      vecs[6]  = '{OP_LD,  16'h0101, 16'h0000, cpu_data_acc_sz_16, 32'h0000_22AB};
      vecs[7]  = '{OP_F32, 16'h0010, 16'h0000, cpu_data_acc_sz_16, 32'hBEEF_C0DE};
      vecs[8]  = '{OP_LD,  16'h0011, 16'h0000, cpu_data_acc_sz_16, 32'h0000_DEBE};
      vecs[9]  = '{OP_F16, 16'h0012, 16'h0000, cpu_data_acc_sz_16, 32'h0000_C0DE};
      vecs[10] = '{OP_LD,  16'h0010, 16'h0000, cpu_data_acc_sz_8,  32'h0000_00EF};
      vecs[11] = '{OP_ST,  16'h0200, 16'h9876, cpu_data_acc_sz_16, 32'h0};
      vecs[12] = '{OP_LD,  16'h0200, 16'h0000, cpu_data_acc_sz_16, 32'h0000_9876};
      vecs[13] = '{OP_F32, 16'h0200, 16'h0000, cpu_data_acc_sz_16, 32'h9876_0F0F};
      vecs[14] = '{OP_LD,  16'h0201, 16'h0000, cpu_data_acc_sz_8,  32'h0000_0098};

      reset = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_word = '0;
      ifetch_req = 1'b0; ifetch_addr = '0; ifetch_is_32 = 1'b0;
      data_rd_req = 1'b0; data_wr_req = 1'b0; data_addr = '0;
      data_wdata = '0; data_sz = cpu_data_acc_sz_16;

      poke(16'h0000, 16'h1234);
      poke(16'hFFFE, 16'hAAAA);
      poke(16'h0100, 16'h3C5A);
      poke(16'h0102, 16'h1122);
      poke(16'h0010, 16'hBEEF);
      poke(16'h0012, 16'hC0DE);
      poke(16'h0202, 16'h0F0F);
      @(posedge clk); #1;
      check_all_zero("reset");

      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

      // Fetch and load both held: four data grants, then a forced fetch.
      ifetch_addr = 16'h0000; ifetch_is_32 = 1'b0;
      data_addr = 16'h0100; data_sz = cpu_data_acc_sz_16;
      ifetch_req = 1'b1; data_rd_req = 1'b1;
      ng = 0;
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk); #1;
         if (data_ack && ifetch_ack) check("starve double_ack", 64'd1, 64'd0);
         if ((data_ack || ifetch_ack) && ng < 32) begin
            gkind[ng] = ifetch_ack ? 1 : 0;
            gcyc[ng]  = c;
            ng++;
         end
      end
      ifetch_req = 1'b0; data_rd_req = 1'b0;
      check("starve grant_count", 64'(ng), 64'd12);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("starve g%0d kind", i),  64'(gkind[i]), 64'(((i % 5) == 4) ? 1 : 0));
         check($sformatf("starve g%0d cycle", i), 64'(gcyc[i]),  64'(2 * i + 1));
      end
      repeat (3) @(posedge clk);
      #1;

      // Simultaneous read and write: write first, read two cycles later.
      data_addr = 16'h0300; data_wdata = 16'h4321; data_sz = cpu_data_acc_sz_16;
      data_rd_req = 1'b1; data_wr_req = 1'b1;
      we0 = n_we; rv0 = n_rvalid; ack1 = -1; ack2 = -1; rv_at = -1;
      wr_at1 = 0; wr_at2 = 1; rd_got = '0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (data_ack) begin
            if (ack1 < 0) begin
               ack1 = c; wr_at1 = int'(mem_inputs.write_data_we); data_wr_req = 1'b0;
            end else if (ack2 < 0) begin
               ack2 = c; wr_at2 = int'(mem_inputs.write_data_we); data_rd_req = 1'b0;
            end
         end
         if (data_rvalid && rv_at < 0) begin
            rv_at = c; rd_got = data_rdata;
         end
      end
      data_rd_req = 1'b0; data_wr_req = 1'b0;
      check("rdwr first_ack_cycle",  64'(ack1),   64'd1);
      check("rdwr first_is_write",   64'(wr_at1), 64'd1);
      check("rdwr second_ack_cycle", 64'(ack2),   64'd3);
      check("rdwr second_is_read",   64'(wr_at2), 64'd0);
      check("rdwr rvalid_cycle",     64'(rv_at),  64'd4);
      check("rdwr rdata",            64'(rd_got), 64'h4321);
      check("rdwr we_cycles",        64'(n_we - we0), 64'd1);
      check("rdwr rvalid_count",     64'(n_rvalid - rv0), 64'd1);

      // Reset pulled low in the middle of a 32-bit fetch's second read.
      ifetch_addr = 16'h0010; ifetch_is_32 = 1'b1; ifetch_req = 1'b1;
      iv0 = n_ivalid;
      @(posedge clk); #1;
      check("rst_mid ack", 64'(ifetch_ack), 64'd1);
      ifetch_req = 1'b0;
      @(posedge clk); #1;
      check("rst_mid busy_before", 64'(busy), 64'd1);
      check("rst_mid hi_addr", 64'(mem_inputs.read_addr_in), 64'h0012);
      #2 reset = 1'b0;
      #1;
      check_all_zero("rst_mid async");
      @(posedge clk); #1;
      check_all_zero("rst_mid held");
      @(negedge clk); reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_mid busy_after", 64'(busy), 64'd0);
      check("rst_mid no_ivalid", 64'(n_ivalid - iv0), 64'd0);
      run_vec(99, vecs[9]);

      check("valid_pulse_max_run", 64'(max_run), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
